potential_decay_engine: RTL

//  Time-multiplexed membrane-potential decay engine. Replaces per-neuron decay instances with one shared datapath.
//  On each timestep_start it sweeps NEURONS potentials held in an external single-port-read/single-port-write RAM.

---
 rtl/potential_decay_pkg.sv | 24 ++
 rtl/fp_pow2_scale.sv | 47 ++++
 rtl/potential_decay_engine.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/potential_decay_pkg.sv
// Shared definitions for the membrane-potential decay engine.
//   - neuron model encodings carried on the engine's model input
//   - sweep FSM state encodings
//   - default floating-point field widths (IEEE-754 single precision)
package potential_decay_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;

  typedef enum logic [1:0] {
    MODEL_LIF   = 2'b00,  // leaky: scale by 2^-k
    MODEL_IF    = 2'b01,  // integrate-and-fire: no decay
    MODEL_RESET = 2'b10,  // clear potential to +0
    MODEL_RSVD  = 2'b11   // reserved, behaves as IF
  } model_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SWEEP = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/fp_pow2_scale.sv
// Combinational scale of a floating-point word by 2^-k.
// Only the exponent field moves; the mantissa is never touched, so the
// result is exact unless the exponent would reach zero, in which case
// the value flushes to a signed zero (no denormal outputs).
// Ports:
//   value   in  DATA_W  word to scale {sign, exponent, mantissa}
//   k       in  4       shift amount
//   result  out DATA_W  scaled word
module fp_pow2_scale
  import potential_decay_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  localparam int DATA_W = 1 + EXP_W + MAN_W
) (
  input  logic [DATA_W-1:0] value,
  input  logic [3:0]        k,
  output logic [DATA_W-1:0] result
);

  logic             sign_s;
  logic [EXP_W-1:0] exp_s;
  logic [MAN_W-1:0] man_s;
  logic [EXP_W-1:0] k_ext_s;

  // Field split and exponent adjustment with zero/inf/NaN/underflow handling
  always_comb begin
    sign_s  = value[DATA_W-1];
    exp_s   = value[DATA_W-2 -: EXP_W];
    man_s   = value[MAN_W-1:0];
    k_ext_s = EXP_W'(k);
    result  = value;
    if (exp_s == {EXP_W{1'b0}}) begin
      // zero stays zero; denormals are flushed keeping the sign
      result = {sign_s, {(DATA_W-1){1'b0}}};
    end else if (exp_s == {EXP_W{1'b1}}) begin
      result = value;
    end else if (k == 4'd0) begin
      result = value;
    end else if (exp_s <= k_ext_s) begin
      result = {sign_s, {(DATA_W-1){1'b0}}};
    end else begin
      result = {sign_s, exp_s - k_ext_s, man_s};
    end
  end

endmodule

// File: rtl/potential_decay_engine.sv
// Time-multiplexed membrane-potential decay engine.
// One shared datapath sweeps all NEURONS potentials in an external RAM on
// every timestep_start: read address a in cycle t, data returns in t+1,
// registered write of address a in t+2, one neuron per cycle.
// Optional build macro DECAY_SKIP_UNCHANGED_EN: suppress the write strobe
// when the new word equals the word read (addresses/data still advance).
// Ports:
//   CLK, RST_N       clock; synchronous active-low reset
//   timestep_start   one-cycle pulse, begins a sweep when idle
//   model            neuron model (LIF/IF/RESET/reserved), latched at start
//   decay_rate       shift k, latched at start
//   busy             high from accepted start until the done cycle inclusive
//   done             one-cycle pulse after the last write
//   overrun          sticky: start seen while busy, cleared by reset only
//   mem_rd_en/addr   RAM read port request
//   mem_rd_data      RAM read data, valid one cycle after mem_rd_en
//   mem_wr_en/addr/data  RAM write port
module potential_decay_engine
  import potential_decay_pkg::*;
#(
  parameter int NEURONS = 1024,
  parameter int ADDR_W  = 10,
  parameter int EXP_W   = DEF_EXP_W,
  parameter int MAN_W   = DEF_MAN_W,
  localparam int DATA_W = 1 + EXP_W + MAN_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              timestep_start,
  input  logic [1:0]        model,
  input  logic [3:0]        decay_rate,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NEURONS - 1);

  state_e              state_r;
  state_e              state_s;
  model_e              model_r;
  logic [3:0]          rate_r;
  logic                p1_vld_r;
  logic [ADDR_W-1:0]   p1_addr_r;
  logic                w_vld_r;
  logic                rd_en_s;
  logic [ADDR_W-1:0]   rd_addr_s;
  logic                start_ok_s;
  logic                last_wr_s;
  logic [DATA_W-1:0]   scaled_s;
  logic [DATA_W-1:0]   result_s;
  logic                wr_en_s;

  // w_vld_r tracks the write slot even when the strobe is suppressed
  assign last_wr_s = w_vld_r && (mem_wr_addr == LAST_ADDR);

  // Next-state and read-address generation
  always_comb begin
    state_s    = state_r;
    rd_en_s    = 1'b0;
    rd_addr_s  = mem_rd_addr;
    start_ok_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (timestep_start) begin
          state_s    = ST_SWEEP;
          rd_en_s    = 1'b1;
          rd_addr_s  = {ADDR_W{1'b0}};
          start_ok_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        // the read being issued now is the last one: stop reading
        if (mem_rd_addr == LAST_ADDR) begin
          state_s = ST_DRAIN;
          rd_en_s = 1'b0;
        end else begin
          rd_en_s   = 1'b1;
          rd_addr_s = mem_rd_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DRAIN: begin
        if (last_wr_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  fp_pow2_scale #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_scale (
    .value  (mem_rd_data),
    .k      (rate_r),
    .result (scaled_s)
  );

  // Stage-2 model selection and write-strobe qualification
  always_comb begin
    result_s = mem_rd_data;
    case (model_r)
      MODEL_LIF:   result_s = scaled_s;
      MODEL_RESET: result_s = {DATA_W{1'b0}};
      MODEL_IF:    result_s = mem_rd_data;
      MODEL_RSVD:  result_s = mem_rd_data;
      default:     result_s = mem_rd_data;
    endcase
`ifdef DECAY_SKIP_UNCHANGED_EN
    wr_en_s = p1_vld_r && (result_s != mem_rd_data);
`else
    wr_en_s = p1_vld_r;
`endif
  end

  // FSM state, status flags and latched sweep configuration
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      model_r <= MODEL_LIF;
      rate_r  <= 4'd0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != ST_IDLE);
      done    <= (state_s == ST_DONE);
      if (start_ok_s) begin
        model_r <= model_e'(model);
        rate_r  <= decay_rate;
      end
      if (timestep_start && (state_r != ST_IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

  // Read request, data-return and write pipeline registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= {ADDR_W{1'b0}};
      p1_vld_r    <= 1'b0;
      p1_addr_r   <= {ADDR_W{1'b0}};
      w_vld_r     <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= {ADDR_W{1'b0}};
      mem_wr_data <= {DATA_W{1'b0}};
    end else begin
      mem_rd_en   <= rd_en_s;
      mem_rd_addr <= rd_addr_s;
      p1_vld_r    <= mem_rd_en;
      p1_addr_r   <= mem_rd_addr;
      w_vld_r     <= p1_vld_r;
      mem_wr_en   <= wr_en_s;
      if (p1_vld_r) begin
        mem_wr_addr <= p1_addr_r;
        mem_wr_data <= result_s;
      end
    end
  end

endmodule
